// File: rtl/lcd_text_buf.sv
// Two-line LCD text buffer: a 32-byte working buffer takes character writes at
// any time; a shadow copy is latched and handed to the LCD bus interface as a
// single transfer whenever the working buffer has changed, with a power-up
// holdoff and a minimum idle gap between transfers.
module lcd_text_buf #(
  parameter logic [21:0] INIT_TC = 22'h3F_FFFF,
  parameter logic [21:0] HOLD_TC = 22'h00_FFFF
) (
  input  logic              I_CLK,
  input  logic              I_RSTF,
  input  logic              I_WR,
  input  logic [4:0]        I_ADDR,
  input  logic [7:0]        I_WDATA,
  input  logic              I_HEX,
  input  logic              I_DONE,
  output logic              O_START,
  output logic [0:15][7:0]  O_WDATA0,
  output logic [0:15][7:0]  O_WDATA1,
  output logic              O_BUSY
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LATCH,
    S_START,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [21:0]      cnt_q, cnt_d;
  logic             dirty_q, dirty_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [0:31][7:0] work_q;
  logic [0:31][7:0] shad_q;
  logic [7:0]       wbyte;

  // Byte to store: raw data, or the low nibble rendered as uppercase ASCII hex.
  always_comb begin
    wbyte = I_WDATA;
    if (I_HEX) begin
      if (I_WDATA[3:0] < 4'd10) wbyte = 8'h30 + {4'h0, I_WDATA[3:0]};
      else                      wbyte = 8'h37 + {4'h0, I_WDATA[3:0]};
    end
  end

  // Next-state, counter, dirty flag and registered output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dirty_d = dirty_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_TC) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      // A write seen in IDLE goes straight to LATCH so the new byte is
      // included in the very next transfer.
      S_IDLE:      if (dirty_q || I_WR) state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_START;
        dirty_d = 1'b0;
      end
      S_START:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (I_DONE) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_TC) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
    // A write coinciding with LATCH keeps dirty set so it gets its own refresh.
    if (I_WR) dirty_d = 1'b1;
    start_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_WAIT_DONE);
  end

  // Control registers.
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      dirty_q <= 1'b1;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  // Working and shadow buffers; the shadow copies pre-write contents on a collision.
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      work_q <= {32{8'h20}};
      shad_q <= {32{8'h20}};
    end else begin
      if (I_WR) work_q[I_ADDR] <= wbyte;
      if (state_q == S_LATCH) shad_q <= work_q;
    end
  end

  assign O_START  = start_q;
  assign O_BUSY   = busy_q;
  assign O_WDATA0 = shad_q[0:15];
  assign O_WDATA1 = shad_q[16:31];

endmodule

// File: tb/tb_lcd_text_buf.sv
// Bench for lcd_text_buf: directed scenarios plus randomized traffic, checked
// every cycle against a timestamp-based model of the refresh protocol.
module tb_lcd_text_buf;

  localparam logic [21:0] INIT_TC = 22'd15;
  localparam logic [21:0] HOLD_TC = 22'd7;
  localparam int IT = 15;
  localparam int HT = 7;

  logic             I_CLK = 1'b0;
  logic             I_RSTF = 1'b1;
  logic             I_WR = 1'b0;
  logic [4:0]       I_ADDR = '0;
  logic [7:0]       I_WDATA = '0;
  logic             I_HEX = 1'b0;
  logic             I_DONE = 1'b0;
  logic             O_START;
  logic             O_BUSY;
  logic [0:15][7:0] O_WDATA0;
  logic [0:15][7:0] O_WDATA1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  lcd_text_buf #(.INIT_TC(INIT_TC), .HOLD_TC(HOLD_TC)) dut (
    .I_CLK(I_CLK), .I_RSTF(I_RSTF), .I_WR(I_WR), .I_ADDR(I_ADDR),
    .I_WDATA(I_WDATA), .I_HEX(I_HEX), .I_DONE(I_DONE), .O_START(O_START),
    .O_WDATA0(O_WDATA0), .O_WDATA1(O_WDATA1), .O_BUSY(O_BUSY)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is the number of rising edges since reset release (mt). The model
  // records when the block becomes free (m_free) and the edge at which a
  // transfer was committed (m_L): shadow copies at m_L+1, O_START is visible
  // after m_L+1, and I_DONE counts from edge m_L+3 onward.
  logic [7:0] m_work[32];
  logic [7:0] m_shad[32];
  bit         m_dirty, m_infl;
  int         m_free, m_L, mt;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    int v;
    if (n < 4'd10) v = 48 + int'(n);
    else           v = 65 + int'(n) - 10;
    return v[7:0];
  endfunction

  always @(posedge I_CLK or negedge I_RSTF) begin
    bit idle_pre, dirty_pre;
    if (!I_RSTF) begin
      mt = 0; m_free = IT + 1; m_infl = 1'b0; m_dirty = 1'b1; m_L = 0;
      for (int i = 0; i < 32; i++) begin
        m_work[i] = 8'h20;
        m_shad[i] = 8'h20;
      end
    end else begin
      mt++;
      idle_pre  = !m_infl && (mt - 1 >= m_free);
      dirty_pre = m_dirty;
      if (m_infl && mt == m_L + 1) begin
        m_shad  = m_work;
        m_dirty = 1'b0;
      end
      if (m_infl && mt >= m_L + 3 && I_DONE) begin
        m_infl = 1'b0;
        m_free = mt + HT + 1;
      end
      if (I_WR) begin
        m_work[I_ADDR] = I_HEX ? to_ascii(I_WDATA[3:0]) : I_WDATA;
        m_dirty = 1'b1;
      end
      if (idle_pre && (dirty_pre || I_WR)) begin
        m_infl = 1'b1;
        m_L    = mt;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge I_CLK) begin
    logic [0:15][7:0] e0, e1;
    if (cmp_en) begin
      for (int i = 0; i < 16; i++) begin
        e0[i] = m_shad[i];
        e1[i] = m_shad[16 + i];
      end
      check1("start", O_START, m_infl && (mt == m_L + 1));
      check1("busy", O_BUSY, m_infl && (mt >= m_L + 1));
      check128("line0", O_WDATA0, e0);
      check128("line1", O_WDATA1, e1);
    end
  end

  // ---------------- stimulus helpers (enter and leave at a negedge) ----------------
  task automatic do_wr(input logic [4:0] a, input logic [7:0] d, input logic h);
    I_WR = 1'b1; I_ADDR = a; I_WDATA = d; I_HEX = h;
    @(negedge I_CLK);
    I_WR = 1'b0; I_HEX = 1'b0;
  endtask

  task automatic pulse_done();
    I_DONE = 1'b1;
    @(negedge I_CLK);
    I_DONE = 1'b0;
  endtask

  // Cycle index: the cycle after the first post-release edge is cycle 0.
  task automatic wait_start(input string name, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (O_START === 1'b1) begin
        at = mt - 1;
        break;
      end
      @(negedge I_CLK);
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL %s: no O_START within %0d cycles (got none, required one)", name, limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, wc, dc;
    logic [0:15][7:0] blank;
    logic [7:0] b;
    blank = {16{8'h20}};

    #1 I_RSTF = 1'b0;
    #1 cmp_en = 1'b1;
    #10;
    check1("rst_start", O_START, 1'b0);
    check1("rst_busy", O_BUSY, 1'b0);
    check128("rst_line0", O_WDATA0, blank);
    check128("rst_line1", O_WDATA1, blank);

    // Power-up refresh with no writes.
    @(negedge I_CLK) I_RSTF = 1'b1;
    wait_start("first_start", 40, c);
    checki("first_start_cycle", c, 17);
    check128("first_line1", O_WDATA1, blank);
    @(negedge I_CLK);
    pulse_done();

    // I_DONE in HOLD and IDLE must be ignored.
    repeat (2) @(negedge I_CLK);
    pulse_done();
    repeat (12) @(negedge I_CLK);
    pulse_done();
    repeat (3) @(negedge I_CLK);

    // Hex write in IDLE: 'B' at line 1 column 3, O_START two cycles later.
    wc = mt - 1;
    do_wr(5'h13, 8'h0B, 1'b1);
    wait_start("hex_start", 10, c);
    checki("hex_latency", c - wc, 2);
    b = O_WDATA1[3];
    checki("hex_byte", int'(b), 8'h42);

    // Write during WAIT_DONE stays out of the shadow until the next transfer.
    @(negedge I_CLK);
    do_wr(5'h00, 8'h41, 1'b0);
    repeat (3) @(negedge I_CLK);
    b = O_WDATA0[0];
    checki("wait_shadow_hold", int'(b), 8'h20);
    dc = mt - 1;
    pulse_done();
    wait_start("second_start", 40, c2);
    checki("hold_gap", c2 - dc, 11);
    b = O_WDATA0[0];
    checki("second_byte", int'(b), 8'h41);
    @(negedge I_CLK);
    pulse_done();
    repeat (12) @(negedge I_CLK);

    // Write on the LATCH cycle: shadow keeps the old byte, another refresh follows.
    do_wr(5'h02, 8'h55, 1'b0);
    do_wr(5'h03, 8'h66, 1'b0);
    check1("coll_start", O_START, 1'b1);
    b = O_WDATA0[2];
    checki("coll_first_byte", int'(b), 8'h55);
    b = O_WDATA0[3];
    checki("coll_old_byte", int'(b), 8'h20);
    @(negedge I_CLK);
    pulse_done();
    wait_start("coll_restart", 40, c);
    b = O_WDATA0[3];
    checki("coll_new_byte", int'(b), 8'h66);
    @(negedge I_CLK);
    pulse_done();

    // Randomized traffic; I_DONE pulses land in arbitrary states.
    for (int i = 0; i < 400; i++) begin
      I_WR    = ($urandom_range(0, 3) == 0);
      I_ADDR  = 5'($urandom_range(0, 31));
      I_WDATA = 8'($urandom_range(0, 255));
      I_HEX   = ($urandom_range(0, 1) == 1);
      I_DONE  = ($urandom_range(0, 5) == 0);
      @(negedge I_CLK);
    end
    I_WR = 1'b0; I_HEX = 1'b0; I_DONE = 1'b0;
    if (O_START) @(negedge I_CLK);
    if (O_BUSY) pulse_done();

    // Reset in WAIT_DONE aborts immediately, then the full holdoff repeats.
    do_wr(5'h1F, 8'h7E, 1'b0);
    wait_start("pre_reset_start", 40, c);
    @(negedge I_CLK);
    check1("pre_reset_busy", O_BUSY, 1'b1);
    #2 I_RSTF = 1'b0;
    #1;
    check1("abort_busy", O_BUSY, 1'b0);
    check1("abort_start", O_START, 1'b0);
    check128("abort_line0", O_WDATA0, blank);
    check128("abort_line1", O_WDATA1, blank);
    @(negedge I_CLK) I_RSTF = 1'b1;
    pulse_done();
    repeat (4) @(negedge I_CLK);
    pulse_done();
    wait_start("restart_start", 40, c);
    checki("restart_cycle", c, 17);
    @(negedge I_CLK);
    pulse_done();
    repeat (5) @(negedge I_CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_text_buf.md
LCD_TEXT_BUF -- requirements
Module: lcd_text_buf

Interface
REQ-001 Parameter INIT_TC, default 22'h3F_FFFF, power-up holdoff in I_CLK cycles before the first O_START; must exceed the LCD controller's own init time.
REQ-002 Parameter HOLD_TC, default 22'h00_FFFF, minimum idle cycles between I_DONE and the next O_START.
REQ-003 I_CLK  in  1  system clock; all logic on its rising edge.
REQ-004 I_RSTF  in  1  asynchronous, active-low reset.
REQ-005 I_WR  in  1  one-cycle character write strobe.
REQ-006 I_ADDR  in  5  character address; bit 4 = line (0/1), bits 3:0 = column 0..15.
REQ-007 I_WDATA  in  8  character byte, or hex nibble in bits 3:0 when I_HEX=1.
REQ-008 I_HEX  in  1  1 = convert I_WDATA[3:0] to ASCII hex before storing.
REQ-009 I_DONE  in  1  one-cycle pulse from the LCD bus interface at transfer end.
REQ-010 O_START  out  1  one-cycle transfer request to the LCD bus interface.
REQ-011 O_WDATA0  out  [0:15][7:0]  line-0 shadow buffer, byte 0 = leftmost column.
REQ-012 O_WDATA1  out  [0:15][7:0]  line-1 shadow buffer.
REQ-013 O_BUSY  out  1  high from O_START until I_DONE, inclusive of the start cycle.

Function
REQ-014 Working buffer: 32 bytes; on I_WR, byte[I_ADDR] <= I_HEX ? asc(I_WDATA[3:0]) : I_WDATA.
- asc(n) = 8'h30+n for n<10; 8'h37+n for n>=10 ('A'..'F', uppercase).
REQ-015 Shadow buffer drives O_WDATA0/1; it changes only in LATCH and holds stable through START and WAIT_DONE.
REQ-016 Dirty flag is set by any I_WR and cleared in LATCH; if I_WR and LATCH coincide, set wins (dirty stays 1).
REQ-017 On an I_WR/LATCH collision, the shadow copies pre-write contents and the write lands only in the working buffer, triggering a later refresh.
REQ-018 State machine states: INIT, IDLE, LATCH, START, WAIT_DONE, HOLD.
REQ-019 INIT: 22-bit counter counts up from 0; at count == INIT_TC -> IDLE, counter cleared.
REQ-020 IDLE: dirty=1 -> LATCH; otherwise remain.
REQ-021 LATCH (1 cycle): shadow <= working buffer, dirty cleared -> START.
REQ-022 START (1 cycle): O_START=1 -> WAIT_DONE.
REQ-023 WAIT_DONE: wait for I_DONE=1 -> HOLD, counter cleared; no timeout.
REQ-024 HOLD: count to HOLD_TC -> IDLE; I_WR during HOLD only sets dirty.
REQ-025 Latency: dirty write in IDLE -> LATCH next cycle -> O_START 2 cycles after the I_WR cycle.
REQ-026 I_DONE outside WAIT_DONE is ignored.
REQ-027 I_WR is accepted in every state, including INIT; writes are never dropped.
REQ-028 Writes to the same address in consecutive cycles: last write wins.
REQ-029 O_START is registered; it is never high in two consecutive cycles and never high while O_BUSY was already high.

Reset
REQ-030 Asynchronous on I_RSTF low; all state returns to its reset value immediately.
REQ-031 Reset values: state INIT, counter 0, dirty 1.
REQ-032 Reset values: working and shadow bytes all 8'h20 (space), O_START 0, O_BUSY 0.
REQ-033 Reset mid-transfer aborts without completing the handshake; after release the block re-enters INIT and, since dirty=1, performs a full refresh.

Verification (sim with INIT_TC=15, HOLD_TC=7)
REQ-034 Release reset, no writes -> O_START high exactly once, at cycle 17 after release; O_WDATA0/1 all 8'h20.
REQ-035 In IDLE, I_WR addr 5'h13, I_HEX=1, data 8'h0B -> O_WDATA1[3]=8'h42 ('B') after LATCH; O_START 2 cycles after I_WR.
REQ-036 I_WR addr 0, data 8'h41 during WAIT_DONE -> O_WDATA0[0] unchanged until I_DONE; after HOLD (8 cycles) a second O_START occurs with O_WDATA0[0]=8'h41.
REQ-037 I_WR in the same cycle as LATCH -> dirty remains 1, shadow holds old byte, a second transfer follows HOLD.
REQ-038 I_DONE pulsed in IDLE, HOLD and INIT -> no state change and no O_START.
REQ-039 Pull I_RSTF low in WAIT_DONE -> O_BUSY=0 and buffers = 8'h20 immediately; after release the INIT holdoff repeats.
